ntt_pm_stream_host: RTL and testbench
=====================================

// Module: ntt_pm_stream_host
// PURPOSE
//  Host-side initiator for the NTT polynomial multiplier (start/done/busy, load, read ports).
//  Accepts 2N input coefficients on a valid/ready stream (A[0..N-1], then B[0..N-1]) and
//  writes each into the multiplier's load port. It then pulses start, waits for done and
//  streams the N product coefficients out on a valid/ready stream, with m_last on the final one.
//  Sits between the system stream fabric and the multiplier core.
// PARAMETERS
//  N              256      polynomial length (power of two)
//  WIDTH          32       coefficient width
//  Q              8380417  modulus, used for input range check
//  ADDR_WIDTH     8        log2(N)
//  READ_LATENCY   0        cycles from pm_read_addr to valid pm_read_data (0..2)
//  TIMEOUT_CYCLES 1<<20    watchdog limit between pm_start and pm_done
// PORTS
//  clk            in   1           clock
//  rst_n          in   1           reset, asynchronous, active-low
//  s_valid        in   1           input coefficient valid
//  s_ready        out  1           input coefficient ready
//  s_data         in   WIDTH       input coefficient
//  s_last         in   1           input marker; expected on coefficient 2N-1
//  m_valid        out  1           result valid
//  m_ready        in   1           result ready
//  m_data         out  WIDTH       result coefficient c[k]
//  m_last         out  1           high with c[N-1]
//  busy           out  1           job in progress (first accept through last result)
//  job_done       out  1           one-cycle pulse after the m_last handshake
//  err_range      out  1           sticky: an input coefficient was >= Q
//  err_frame      out  1           sticky: s_last placement differed from index 2N-1
//  err_timeout    out  1           sticky: watchdog expired
//  pm_start       out  1           multiplier start
//  pm_done        in   1           multiplier done
//  pm_busy        in   1           multiplier busy
//  pm_load_coeff  out  1           multiplier load strobe
//  pm_load_sel    out  1           0 = A, 1 = B
//  pm_load_addr   out  ADDR_WIDTH  load address
//  pm_load_data   out  WIDTH       load data
//  pm_read_addr   out  ADDR_WIDTH  result read address
//  pm_read_data   in   WIDTH       result read data
// BEHAVIOUR
//  Reset: all outputs 0, FSM in IDLE, counters 0, error flags cleared.
//  FSM states: IDLE -> LOAD -> START -> WAIT -> READ -> FIN -> IDLE.
//  - IDLE: s_ready=0. Go to LOAD when s_valid=1 and pm_busy=0. Clear the err_* flags here (job start).
//  - LOAD: s_ready = !pm_busy. On each accept (idx 0..2N-1), register next cycle: pm_load_coeff=1,
//    pm_load_sel=idx[ADDR_WIDTH], pm_load_addr=idx[ADDR_WIDTH-1:0], pm_load_data=s_data.
//    s_data>=Q sets err_range; the value still loads unchanged. s_last at idx!=2N-1, or missing at
//    idx 2N-1, sets err_frame. Loading never terminates early. After accept 2N-1, go to START.
//  - START: pm_start=1 for exactly one cycle (the registered load for 2N-1 has already issued).
//    Go to WAIT.
//  - WAIT: count cycles. On pm_done (a one-cycle pulse), go to READ. If count reaches
//    TIMEOUT_CYCLES, set err_timeout and go to IDLE with no output.
//  - READ: pipelined reads, addr 0..N-1, into a 2-entry output FIFO. Issue a read when
//    (fifo_count + in_flight) < 2 and addr < N. Data is captured READ_LATENCY cycles after issue
//    (combinational when 0). m_valid = FIFO not empty. m_last = (entry index == N-1).
//    Sustained rate is 1 coeff/cycle at READ_LATENCY=0 and m_ready=1.
//  - FIN: entered on the m_last handshake. job_done=1 for one cycle, then go to IDLE.
//  - busy=1 in LOAD..FIN.
//  - The s_valid/s_ready and m_valid/m_ready handshakes follow standard rules: data is held stable
//    while valid=1 and ready=0, and m_valid never drops without a handshake.
//  - Edge cases:
//    - Simultaneous FIFO push and pop keeps the count unchanged.
//    - m_ready=0 for arbitrarily long causes no read issue and no data loss.
//    - Address counters are ADDR_WIDTH+1 bits wide to avoid wrap at N.
//    - pm_busy=1 while in IDLE keeps s_ready low.
//    - pm_done seen outside WAIT is ignored.
//    - Reset asserted mid-job aborts immediately and all outputs return to their reset values.
// STRUCTURE
//  Package ntt_host_pkg: state_t enum, IDX_W=$clog2(2N+1), CNT_W=$clog2(TIMEOUT_CYCLES+1).
//  Sub-module ntt_host_rd_fifo: 2-entry sync FIFO {data, last} with count and full/empty outputs.
//  The READ_LATENCY delay line (valid + last + index) stays inline in this module.
// TESTING
//  1. N=8, Q=17, A=x+1, B=x-1, m_ready=1. Expect results [16,0,1,0,0,0,0,0], m_last on beat 7,
//     one job_done pulse, and no error flags set.
//  2. Backpressure: m_ready toggles with a 1/3 duty cycle, READ_LATENCY=2. The output stream is
//     identical to test 1, with no duplicated or dropped beats.
//  3. Input s_data=Q at idx 3 sets err_range=1 and the job completes. err_range clears at the
//     next job's first accept.
//  4. s_last asserted at idx 5. err_frame=1, loading continues to 2N, and the job completes.
//  5. Model withholds pm_done with TIMEOUT_CYCLES=64. err_timeout=1 at cycle 64 of WAIT,
//     FSM returns to IDLE, and m_valid never asserts.
//  6. rst_n pulled low during READ at beat 3. All outputs read 0 in the same cycle, and a fresh
//     job afterwards produces the test 1 result.

Source files
------------

// File: rtl/ntt_host_pkg.sv
// Shared types and width helpers for the NTT multiplier host initiator.
package ntt_host_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_START,
      ST_WAIT,
      ST_READ,
      ST_FIN
   } state_t;

   // Load index spans 0..2N-1 and must still be comparable against 2N
   function automatic int idx_width(input int n);
      return $clog2(2 * n + 1);
   endfunction

   function automatic int cnt_width(input int t);
      return $clog2(t + 1);
   endfunction

endpackage

// File: rtl/ntt_host_rd_fifo.sv
// Two-entry output FIFO holding result coefficients with their last marker.
module ntt_host_rd_fifo #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             push_last,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             head_last,
   output logic [1:0]       count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_data [2];
   logic [1:0]       mem_last;
   logic             wr_ptr;
   logic             rd_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_data[0] <= '0;
         mem_data[1] <= '0;
         mem_last    <= '0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         count       <= 2'd0;
      end else begin
         if (push) begin
            mem_data[wr_ptr] <= push_data;
            mem_last[wr_ptr] <= push_last;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   assign head_data = mem_data[rd_ptr];
   assign head_last = mem_last[rd_ptr];
   assign full      = (count == 2'd2);
   assign empty     = (count == 2'd0);

endmodule

// File: rtl/ntt_pm_stream_host.sv
// Host initiator: streams 2N coefficients into the NTT multiplier, runs it,
// and streams the N product coefficients back out.
//
// state    | meaning
// ST_IDLE  | waiting for first input beat while multiplier idle
// ST_LOAD  | accepting A[0..N-1] then B[0..N-1] into the load port
// ST_START | one-cycle multiplier start
// ST_WAIT  | waiting for pm_done, watchdog running
// ST_READ  | reading results into the output FIFO and draining it
// ST_FIN   | job_done pulse, back to idle
module ntt_pm_stream_host
   import ntt_host_pkg::*;
#(
   parameter int N              = 256,
   parameter int WIDTH          = 32,
   parameter int Q              = 8380417,
   parameter int ADDR_WIDTH     = 8,
   parameter int READ_LATENCY   = 0,
   parameter int TIMEOUT_CYCLES = 1 << 20
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [WIDTH-1:0]      s_data,
   input  logic                  s_last,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [WIDTH-1:0]      m_data,
   output logic                  m_last,
   output logic                  busy,
   output logic                  job_done,
   output logic                  err_range,
   output logic                  err_frame,
   output logic                  err_timeout,
   output logic                  pm_start,
   input  logic                  pm_done,
   input  logic                  pm_busy,
   output logic                  pm_load_coeff,
   output logic                  pm_load_sel,
   output logic [ADDR_WIDTH-1:0] pm_load_addr,
   output logic [WIDTH-1:0]      pm_load_data,
   output logic [ADDR_WIDTH-1:0] pm_read_addr,
   input  logic [WIDTH-1:0]      pm_read_data
);

   localparam int IDX_W = idx_width(N);
   localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
   localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(2 * N - 1);
   localparam logic [ADDR_WIDTH:0] RD_END    = (ADDR_WIDTH + 1)'(N);
   localparam logic [ADDR_WIDTH:0] RD_LAST   = (ADDR_WIDTH + 1)'(N - 1);
   localparam logic [CNT_W-1:0]    WAIT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [WIDTH-1:0]    Q_W       = WIDTH'(Q);

   state_t                state;
   logic [IDX_W-1:0]      ld_idx;
   logic [CNT_W-1:0]      wait_cnt;
   logic [ADDR_WIDTH:0]   rd_addr;
   logic                  s_accept;
   logic                  rd_issue;
   logic                  push;
   logic [ADDR_WIDTH:0]   push_idx;
   logic [1:0]            in_flight;
   logic                  pop;
   logic [1:0]            fifo_count;
   logic                  fifo_full;
   logic                  fifo_empty;

   assign s_ready      = (state == ST_LOAD) && !pm_busy;
   assign s_accept     = s_valid && s_ready;
   assign busy         = (state != ST_IDLE);
   assign m_valid      = !fifo_empty;
   assign pop          = m_valid && m_ready;
   assign pm_read_addr = rd_addr[ADDR_WIDTH-1:0];

   // Reserve FIFO space for every read still travelling through the memory pipeline
   assign rd_issue = (state == ST_READ) && (rd_addr < RD_END) && !fifo_full &&
                     (({1'b0, fifo_count} + {1'b0, in_flight}) < 3'd2);

   if (READ_LATENCY == 0) begin : g_lat0
      assign push      = rd_issue;
      assign push_idx  = rd_addr;
      assign in_flight = 2'd0;
   end else begin : g_latn
      logic [READ_LATENCY-1:0] dl_vld;
      logic [ADDR_WIDTH:0]     dl_idx [READ_LATENCY];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            dl_vld <= '0;
            for (int i = 0; i < READ_LATENCY; i++)
               dl_idx[i] <= '0;
         end else begin
            dl_vld[0] <= rd_issue;
            dl_idx[0] <= rd_addr;
            for (int i = 1; i < READ_LATENCY; i++) begin
               dl_vld[i] <= dl_vld[i-1];
               dl_idx[i] <= dl_idx[i-1];
            end
         end
      end

      assign push      = dl_vld[READ_LATENCY-1];
      assign push_idx  = dl_idx[READ_LATENCY-1];
      assign in_flight = 2'($countones(dl_vld));
   end

   ntt_host_rd_fifo #(.WIDTH(WIDTH)) u_rd_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (pm_read_data),
      .push_last (push_idx == RD_LAST),
      .pop       (pop),
      .head_data (m_data),
      .head_last (m_last),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         ld_idx        <= '0;
         wait_cnt      <= '0;
         rd_addr       <= '0;
         pm_start      <= 1'b0;
         pm_load_coeff <= 1'b0;
         pm_load_sel   <= 1'b0;
         pm_load_addr  <= '0;
         pm_load_data  <= '0;
         job_done      <= 1'b0;
         err_range     <= 1'b0;
         err_frame     <= 1'b0;
         err_timeout   <= 1'b0;
      end else begin
         pm_load_coeff <= 1'b0;
         pm_start      <= 1'b0;
         job_done      <= 1'b0;
         if (rd_issue)
            rd_addr <= rd_addr + 1'b1;

         case (state)
            ST_IDLE: begin
               if (s_valid && !pm_busy) begin
                  state       <= ST_LOAD;
                  ld_idx      <= '0;
                  err_range   <= 1'b0;
                  err_frame   <= 1'b0;
                  err_timeout <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (s_accept) begin
                  pm_load_coeff <= 1'b1;
                  pm_load_sel   <= ld_idx[ADDR_WIDTH];
                  pm_load_addr  <= ld_idx[ADDR_WIDTH-1:0];
                  pm_load_data  <= s_data;
                  if (s_data >= Q_W)
                     err_range <= 1'b1;
                  if (s_last != (ld_idx == IDX_LAST))
                     err_frame <= 1'b1;
                  if (ld_idx == IDX_LAST) begin
                     state  <= ST_START;
                     ld_idx <= '0;
                  end else begin
                     ld_idx <= ld_idx + 1'b1;
                  end
               end
            end
            ST_START: begin
               pm_start <= 1'b1;
               wait_cnt <= WAIT_LOAD;
               state    <= ST_WAIT;
            end
            ST_WAIT: begin
               if (pm_done) begin
                  state   <= ST_READ;
                  rd_addr <= '0;
               end else if (wait_cnt == '0) begin
                  err_timeout <= 1'b1;
                  state       <= ST_IDLE;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            ST_READ: begin
               if (pop && m_last) begin
                  job_done <= 1'b1;
                  state    <= ST_FIN;
               end
            end
            ST_FIN: begin
               rd_addr <= '0;
               state   <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ntt_pm_stream_host.sv
// Directed bench: two hosts (read latency 0 and 2) each driving a small
// negacyclic multiplier model with N=8, Q=17.
module tb_ntt_pm_stream_host;

   logic clk;
   logic rst_n;

   logic [1:0]       s_valid, s_last, m_ready, pm_busy_f, withhold;
   logic [1:0][31:0] s_data;
   logic [1:0]       s_ready, m_valid, m_last, busy, job_done;
   logic [1:0]       err_range, err_frame, err_timeout;
   logic [1:0]       pm_start, pm_load_coeff, pm_load_sel;
   logic [1:0][31:0] m_data, pm_load_data;
   logic [1:0][2:0]  pm_load_addr, pm_read_addr;

   int total, bad;
   int st_cnt [2];
   int dn_cnt [2];
   int mv_cnt [2];
   int exp_c  [8];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_inst
      logic        pm_done_g;
      logic [31:0] rdata_g;
      logic [31:0] a_m [8];
      logic [31:0] b_m [8];
      logic [31:0] c_m [8];
      int          dcnt;

      ntt_pm_stream_host #(
         .N(8), .WIDTH(32), .Q(17), .ADDR_WIDTH(3),
         .READ_LATENCY(2 * g), .TIMEOUT_CYCLES(64)
      ) u_dut (
         .clk(clk), .rst_n(rst_n),
         .s_valid(s_valid[g]), .s_ready(s_ready[g]), .s_data(s_data[g]), .s_last(s_last[g]),
         .m_valid(m_valid[g]), .m_ready(m_ready[g]), .m_data(m_data[g]), .m_last(m_last[g]),
         .busy(busy[g]), .job_done(job_done[g]),
         .err_range(err_range[g]), .err_frame(err_frame[g]), .err_timeout(err_timeout[g]),
         .pm_start(pm_start[g]), .pm_done(pm_done_g), .pm_busy(pm_busy_f[g]),
         .pm_load_coeff(pm_load_coeff[g]), .pm_load_sel(pm_load_sel[g]),
         .pm_load_addr(pm_load_addr[g]), .pm_load_data(pm_load_data[g]),
         .pm_read_addr(pm_read_addr[g]), .pm_read_data(rdata_g)
      );

      always @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            pm_done_g <= 1'b0;
            dcnt      <= 0;
         end else begin
            pm_done_g <= 1'b0;
            if (pm_start[g])
               dcnt <= 5;
            else if (dcnt > 0) begin
               dcnt <= dcnt - 1;
               if (dcnt == 1 && !withhold[g])
                  pm_done_g <= 1'b1;
            end
         end
      end

      always @(posedge clk) begin : mdl
         int acc [8];
         int p;
         if (pm_load_coeff[g]) begin
            if (pm_load_sel[g]) b_m[pm_load_addr[g]] <= pm_load_data[g];
            else                a_m[pm_load_addr[g]] <= pm_load_data[g];
         end
         if (pm_start[g]) begin
            for (int i = 0; i < 8; i++) acc[i] = 0;
            for (int i = 0; i < 8; i++)
               for (int j = 0; j < 8; j++) begin
                  p = int'(a_m[i] % 17) * int'(b_m[j] % 17);
                  if (i + j < 8) acc[i+j] += p;
                  else           acc[i+j-8] -= p;
               end
            for (int i = 0; i < 8; i++)
               c_m[i] <= 32'(((acc[i] % 17) + 17) % 17);
         end
      end

      if (g == 0) begin : g_l0
         assign rdata_g = c_m[pm_read_addr[g]];
      end else begin : g_l2
         logic [31:0] r1, r2;
         always @(posedge clk) begin
            r1 <= c_m[pm_read_addr[g]];
            r2 <= r1;
         end
         assign rdata_g = r2;
      end
   end

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (pm_start[d]) st_cnt[d]++;
         if (job_done[d]) dn_cnt[d]++;
         if (m_valid[d])  mv_cnt[d]++;
      end
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] outs(input int d);
      return {s_ready[d], m_valid[d], m_data[d], m_last[d], busy[d], job_done[d],
              err_range[d], err_frame[d], err_timeout[d], pm_start[d], pm_load_coeff[d],
              pm_load_sel[d], pm_load_addr[d], pm_load_data[d], pm_read_addr[d]};
   endfunction

   // A = x+1, B = x-1 (b0 = 16); bad_idx injects the value Q
   function automatic logic [31:0] coef(input int i, input int bad_idx);
      if (i == bad_idx) return 32'd17;
      if (i < 8)        return (i < 2) ? 32'd1 : 32'd0;
      if (i == 8)       return 32'd16;
      return (i == 9) ? 32'd1 : 32'd0;
   endfunction

   task automatic send(input int d, input int bad_idx, input int last_idx);
      int n;
      int stalls = 0;
      for (int i = 0; i < 16; i++) begin
         s_valid[d] = 1'b1;
         s_data[d]  = coef(i, bad_idx);
         s_last[d]  = (i == last_idx);
         n = 0;
         while (!s_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
         end
         if (n >= 50) stalls++;
         @(negedge clk);
      end
      s_valid[d] = 1'b0;
      s_last[d]  = 1'b0;
      chk("send_stall", 128'(stalls), 128'd0);
   endtask

   task automatic recv(input int d, input bit bp, input int stop_after, input string tag);
      int got = 0;
      int cyc = 0;
      int dn0;
      dn0 = dn_cnt[d];
      while (got < stop_after && cyc < 400) begin
         @(negedge clk);
         cyc++;
         m_ready[d] = bp ? (cyc % 3 == 0) : 1'b1;
         if (m_valid[d] && m_ready[d]) begin
            chk({tag, "_data"}, 128'(m_data[d]), 128'(exp_c[got]));
            chk({tag, "_last"}, 128'(m_last[d]), 128'(got == 7));
            got++;
         end
      end
      chk({tag, "_beats"}, 128'(got), 128'(stop_after));
      if (stop_after == 8) begin
         m_ready[d] = 1'b1;
         repeat (4) @(negedge clk);
         chk({tag, "_jobdone"}, 128'(dn_cnt[d] - dn0), 128'd1);
         chk({tag, "_idle"}, {126'd0, busy[d], m_valid[d]}, 128'd0);
      end
   endtask

   initial begin
      int s0, mv0, n;
      total = 0; bad = 0;
      exp_c = '{16, 0, 1, 0, 0, 0, 0, 0};
      st_cnt = '{0, 0}; dn_cnt = '{0, 0}; mv_cnt = '{0, 0};
      s_valid = '0; s_last = '0; s_data = '0; m_ready = '1; pm_busy_f = '0; withhold = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_outs0", outs(0), 128'd0);
      chk("rst_outs1", outs(1), 128'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // basic job, latency 0
      s0 = st_cnt[0];
      send(0, -1, 15);
      chk("t1_busy", 128'(busy[0]), 128'd1);
      recv(0, 1'b0, 8, "t1");
      chk("t1_start_once", 128'(st_cnt[0] - s0), 128'd1);
      chk("t1_errs", {err_range[0], err_frame[0], err_timeout[0]}, 128'd0);

      // pm_busy blocks the job from starting, then backpressure at latency 2
      pm_busy_f[1] = 1'b1;
      s_valid[1]   = 1'b1;
      repeat (5) @(negedge clk);
      chk("pmbusy_idle", {s_ready[1], busy[1]}, 128'd0);
      pm_busy_f[1] = 1'b0;
      send(1, -1, 15);
      recv(1, 1'b1, 8, "t2");
      chk("t2_errs", {err_range[1], err_frame[1], err_timeout[1]}, 128'd0);

      // out-of-range coefficient
      send(0, 3, 15);
      recv(0, 1'b0, 8, "t3");
      chk("t3_errs", {err_range[0], err_frame[0]}, 128'b10);

      // early s_last; err_range from the previous job must clear
      send(0, -1, 5);
      chk("t4_range_clr", 128'(err_range[0]), 128'd0);
      recv(0, 1'b0, 8, "t4");
      chk("t4_errs", {err_range[0], err_frame[0]}, 128'b01);

      // watchdog
      withhold[0] = 1'b1;
      mv0 = mv_cnt[0];
      send(0, -1, 15);
      n = 0;
      while (!pm_start[0] && n < 100) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      while (!err_timeout[0] && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("t5_timeout_cyc", 128'(n), 128'd64);
      chk("t5_idle", 128'(busy[0]), 128'd0);
      repeat (10) @(negedge clk);
      chk("t5_no_mvalid", 128'(mv_cnt[0] - mv0), 128'd0);
      withhold[0] = 1'b0;

      // reset in the middle of reading
      send(0, -1, 15);
      chk("t6_tmo_clr", 128'(err_timeout[0]), 128'd0);
      recv(0, 1'b0, 3, "t6a");
      rst_n = 1'b0;
      #1;
      chk("t6_rst_outs", outs(0), 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(0, -1, 15);
      recv(0, 1'b0, 8, "t6b");
      chk("t6_errs", {err_range[0], err_frame[0], err_timeout[0]}, 128'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
